// File: rtl/mux_serial_adder.sv
// Bit-serial adder (LSB first) built on 2:1-mux sum and carry cells, with a start/busy/done handshake.
// Optional MUX_SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).

module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// Carry-out of a full adder: propagate selects incoming carry, otherwise generate equals a.
module mux_carryOut_logic (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out
);
  logic b_n;
  logic p;

  assign b_n = ~b;

  mux2 u_prop (.sel(a), .d0(b), .d1(b_n), .y(p));
  mux2 u_cout (.sel(p), .d0(a), .d1(c_in), .y(c_out));
endmodule

// Sum bit of a full adder as two cascaded mux-based XOR slices.
module mux_sum_logic (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s
);
  logic b_n;
  logic c_n;
  logic p;

  assign b_n = ~b;
  assign c_n = ~c_in;

  mux2 u_prop (.sel(a), .d0(b), .d1(b_n), .y(p));
  mux2 u_sum  (.sel(p), .d0(c_in), .d1(c_n), .y(s));
endmodule

module mux_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef MUX_SERIAL_ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef MUX_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_full;
  logic             accept;
  logic             last_bit;

  mux_sum_logic u_sum (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c_in (carry_q),
    .s    (sum_bit)
  );

  mux_carryOut_logic u_carry (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .c_out (carry_nxt)
  );

  // New bit enters at the MSB; after WIDTH shifts res_full holds the full sum.
  assign res_full = {sum_bit, r_sh_q};
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef MUX_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy_d  = (state_d == SHIFT);
    done_d  = (state_d == DONE);

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      r_sh_d  = '0;
      carry_d = c_in;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      r_sh_d  = res_full[WIDTH-1:1];
      carry_d = carry_nxt;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        sum_d   = res_full;
        c_out_d = carry_nxt;
`ifdef MUX_SERIAL_ADDER_OVF_EN
        // carry_q here is the carry into the MSB
        ovf_d   = carry_q ^ carry_nxt;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef MUX_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef MUX_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef MUX_SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_mux_serial_adder.sv
// Scoreboard bench for mux_serial_adder (WIDTH=8); checks ovf when MUX_SERIAL_ADDER_OVF_EN is defined.

module tb_mux_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef MUX_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  mux_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef MUX_SERIAL_ADDER_OVF_EN
    .c_out (c_out),
    .ovf   (ovf)
`else
    .c_out (c_out)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               start_cyc;
    string            name;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every done and checks hold/latency/busy length.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      held_sum  = '0;
      held_cout = 1'b0;
    end else begin
      if (busy) busy_cnt = busy_cnt + 1;
      if (done) begin
        done_cnt      = done_cnt + 1;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done_cnt), 32'(0));
        end else begin
          e = q.pop_front();
          chk({e.name, "_sum"}, 32'(sum), 32'(e.sum));
          chk({e.name, "_cout"}, 32'(c_out), 32'(e.cout));
`ifdef MUX_SERIAL_ADDER_OVF_EN
          chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
          chk({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(WIDTH));
          chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        end
        held_sum  = sum;
        held_cout = c_out;
        busy_cnt  = 0;
      end else begin
        chk("sum_hold", 32'(sum), 32'(held_sum));
        chk("cout_hold", 32'(c_out), 32'(held_cout));
      end
    end
  end

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    if (done !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: done not seen within 40 cycles", nm);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                       input string nm);
    exp_t e;
    @(posedge clk); #1;
    a = ai; b = bi; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.start_cyc = cyc; e.name = nm;
    q.push_back(e);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int saved;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_cout", 32'(c_out), 32'(0));
`ifdef MUX_SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "0f_01"); wait_done("0f_01");
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01"); wait_done("ff_01");
    issue(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ff_00_c"); wait_done("ff_00_c");
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01"); wait_done("7f_01");

    // Back-to-back: start held through DONE.
    @(posedge clk); #1;
    a = 8'h55; b = 8'hAA; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    e.sum = 8'hFF; e.cout = 1'b0; e.ovf = 1'b0; e.start_cyc = cyc; e.name = "b2b_first";
    q.push_back(e);
    a = 8'h80; b = 8'h80; c_in = 1'b1;
    wait_done("b2b_first");
    @(posedge clk); #1;
    e.sum = 8'h01; e.cout = 1'b1; e.ovf = 1'b1; e.start_cyc = cyc; e.name = "b2b_second";
    q.push_back(e);
    start = 1'b0;
    wait_done("b2b_second");
    @(posedge clk); #1;
    chk("b2b_done_gap", 32'(last_done_cyc - prev_done_cyc), 32'(WIDTH + 1));

    // start pulsed mid-SHIFT with other operands must be ignored.
    saved = done_cnt;
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "ignore_start");
    repeat (3) @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore_start");
    repeat (WIDTH + 3) @(posedge clk);
    #1 chk("ignore_single_done", 32'(done_cnt - saved), 32'(1));

    // Asynchronous reset in the middle of an operation.
    issue(8'h3C, 8'h3C, 1'b0, 8'h78, 1'b0, 1'b0, "aborted");
    repeat (3) @(posedge clk);
    saved = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(c_out), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    repeat (WIDTH + 4) @(posedge clk);
    #1 chk("abort_no_done", 32'(done_cnt), 32'(saved));
    chk("abort_idle_busy", 32'(busy), 32'(0));

    issue(8'h3C, 8'h3C, 1'b0, 8'h78, 1'b0, 1'b0, "after_reset"); wait_done("after_reset");
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01_again"); wait_done("ff_01_again");
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
